// File: rtl/eth_block_lock_if.sv
// Gearbox-side bundle for the 64b/66b block-lock controller: header beats in,
// slip request and lock status out.
interface eth_block_lock_if;
    logic        i_data_valid;
    logic        i_headervalid;
    logic [1:0]  i_header;
    logic        o_slip;
    logic        o_block_lock;
    logic [15:0] o_slip_count;
    logic        o_hi_ber;

    // Driver side (gearbox / testbench).
    modport master (
        output i_data_valid, i_headervalid, i_header,
        input  o_slip, o_block_lock, o_slip_count, o_hi_ber
    );

    // Block-lock controller side.
    modport slave (
        input  i_data_valid, i_headervalid, i_header,
        output o_slip, o_block_lock, o_slip_count, o_hi_ber
    );
endinterface

// File: rtl/eth_block_lock.sv
// eth_block_lock: 64b/66b receive block-lock controller.
// Searches for LOCK_COUNT consecutive good sync headers. While searching, or
// on INVALID_LIMIT bad headers in a locked window, it requests a one-bit
// gearbox slip and then ignores the link for SLIP_WAIT_CYCLES clocks.
// Optional hi-BER monitor enabled by defining ETH_BLOCK_LOCK_HIBER_EN.
module eth_block_lock #(
    parameter int unsigned LOCK_COUNT       = 64,
    parameter int unsigned INVALID_LIMIT    = 16,
    parameter int unsigned SLIP_WAIT_CYCLES = 32,
    parameter int unsigned HIBER_WINDOW     = 1024
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    eth_block_lock_if.slave  bus
);

    localparam int unsigned SH_W   = $clog2(LOCK_COUNT + 1);
    localparam int unsigned INV_W  = $clog2(INVALID_LIMIT + 1);
    localparam int unsigned WAIT_W = $clog2(SLIP_WAIT_CYCLES + 1);
    localparam int unsigned HB_W   = $clog2(HIBER_WINDOW + 1);

    typedef enum logic [1:0] {
        SEARCH    = 2'd0,
        LOCKED    = 2'd1,
        SLIP_WAIT = 2'd2
    } state_t;

    state_t              state_q, state_d;
    logic [SH_W-1:0]     sh_cnt_q, sh_cnt_d;
    logic [INV_W-1:0]    inv_cnt_q, inv_cnt_d;
    logic [WAIT_W-1:0]   wait_cnt_q, wait_cnt_d;
    logic                lock_q, lock_d;
    logic                slip_q, slip_d;
    logic [15:0]         slip_cnt_q, slip_cnt_d;
    logic                slip_now;

    logic hdr_evt;
    logic hdr_good;

    // Header qualification: a header only counts on a valid beat.
    assign hdr_evt  = bus.i_data_valid & bus.i_headervalid;
    assign hdr_good = bus.i_header[1] ^ bus.i_header[0];

    // State register and all lock-path counters.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q    <= SEARCH;
            sh_cnt_q   <= '0;
            inv_cnt_q  <= '0;
            wait_cnt_q <= '0;
            lock_q     <= 1'b0;
            slip_q     <= 1'b0;
            slip_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            sh_cnt_q   <= sh_cnt_d;
            inv_cnt_q  <= inv_cnt_d;
            wait_cnt_q <= wait_cnt_d;
            lock_q     <= lock_d;
            slip_q     <= slip_d;
            slip_cnt_q <= slip_cnt_d;
        end
    end

    // Next-state logic: header evaluation, window handling and slip requests.
    always_comb begin
        state_d    = state_q;
        sh_cnt_d   = sh_cnt_q;
        inv_cnt_d  = inv_cnt_q;
        wait_cnt_d = wait_cnt_q;
        lock_d     = lock_q;
        slip_d     = 1'b0;
        slip_cnt_d = slip_cnt_q;
        slip_now   = 1'b0;

        case (state_q)
            SEARCH: begin
                if (hdr_evt) begin
                    if (!hdr_good) begin
                        slip_now = 1'b1;
                    end else if (sh_cnt_q == SH_W'(LOCK_COUNT - 1)) begin
                        state_d   = LOCKED;
                        lock_d    = 1'b1;
                        sh_cnt_d  = '0;
                        inv_cnt_d = '0;
                    end else begin
                        sh_cnt_d = sh_cnt_q + SH_W'(1);
                    end
                end
            end
            LOCKED: begin
                if (hdr_evt) begin
                    // Invalid-limit check wins over a coincident window end.
                    if (!hdr_good && (inv_cnt_q == INV_W'(INVALID_LIMIT - 1))) begin
                        lock_d   = 1'b0;
                        slip_now = 1'b1;
                    end else if (sh_cnt_q == SH_W'(LOCK_COUNT - 1)) begin
                        sh_cnt_d  = '0;
                        inv_cnt_d = '0;
                    end else begin
                        sh_cnt_d  = sh_cnt_q + SH_W'(1);
                        inv_cnt_d = inv_cnt_q + INV_W'(!hdr_good);
                    end
                end
            end
            SLIP_WAIT: begin
                // Counts every clock; headers are discarded while waiting.
                if (wait_cnt_q == '0) begin
                    state_d = SEARCH;
                end else begin
                    wait_cnt_d = wait_cnt_q - WAIT_W'(1);
                end
            end
            default: begin
                state_d = SEARCH;
            end
        endcase

        if (slip_now) begin
            state_d    = SLIP_WAIT;
            slip_d     = 1'b1;
            sh_cnt_d   = '0;
            inv_cnt_d  = '0;
            wait_cnt_d = WAIT_W'(SLIP_WAIT_CYCLES - 1);
            if (slip_cnt_q != 16'hFFFF) begin
                slip_cnt_d = slip_cnt_q + 16'd1;
            end
        end
    end

    assign bus.o_slip       = slip_q;
    assign bus.o_block_lock = lock_q;
    assign bus.o_slip_count = slip_cnt_q;

`ifdef ETH_BLOCK_LOCK_HIBER_EN
    logic [HB_W-1:0] hb_win_q, hb_win_d;
    logic [4:0]      hb_bad_q, hb_bad_d, hb_bad_inc;
    logic            hi_ber_q, hi_ber_d;

    // Hi-BER monitor registers.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hb_win_q <= '0;
            hb_bad_q <= '0;
            hi_ber_q <= 1'b0;
        end else begin
            hb_win_q <= hb_win_d;
            hb_bad_q <= hb_bad_d;
            hi_ber_q <= hi_ber_d;
        end
    end

    // Hi-BER window accounting; only active while lock is held.
    always_comb begin
        hb_win_d   = hb_win_q;
        hb_bad_d   = hb_bad_q;
        hi_ber_d   = hi_ber_q;
        hb_bad_inc = hb_bad_q;
        if (!hdr_good && (hb_bad_q != 5'd16)) begin
            hb_bad_inc = hb_bad_q + 5'd1;
        end

        if (!lock_d) begin
            hb_win_d = '0;
            hb_bad_d = '0;
            hi_ber_d = 1'b0;
        end else if (lock_q && hdr_evt) begin
            if (hb_win_q == HB_W'(HIBER_WINDOW - 1)) begin
                hi_ber_d = (hb_bad_inc >= 5'd16);
                hb_win_d = '0;
                hb_bad_d = '0;
            end else begin
                hb_win_d = hb_win_q + HB_W'(1);
                hb_bad_d = hb_bad_inc;
                hi_ber_d = hi_ber_q | (hb_bad_inc == 5'd16);
            end
        end
    end

    assign bus.o_hi_ber = hi_ber_q;
`else
    // Monitor compiled out; window size kept only so the parameter is consumed.
    logic [HB_W-1:0] unused_hiber_window;
    assign unused_hiber_window = HB_W'(HIBER_WINDOW);
    assign bus.o_hi_ber        = 1'b0;
`endif

endmodule

// File: tb/tb_eth_block_lock.sv
// Directed testbench for eth_block_lock (64-header lock, 16 invalid limit,
// 32-cycle slip wait; hi-BER window 128 when ETH_BLOCK_LOCK_HIBER_EN is set).
module tb_eth_block_lock;

    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_mis;
    int   n_slip;

    eth_block_lock_if bus ();

    eth_block_lock #(
        .LOCK_COUNT       (64),
        .INVALID_LIMIT    (16),
        .SLIP_WAIT_CYCLES (32),
        .HIBER_WINDOW     (128)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Count slip pulses, sampled mid-cycle.
    always @(negedge clk) begin
        if (bus.o_slip === 1'b1) n_slip++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic beat(input logic dv, input logic hv, input logic [1:0] h);
        @(negedge clk);
        bus.i_data_valid  = dv;
        bus.i_headervalid = hv;
        bus.i_header      = h;
    endtask

    task automatic hdrs(input int n, input logic [1:0] h);
        for (int i = 0; i < n; i++) beat(1'b1, 1'b1, h);
    endtask

    task automatic idle();
        beat(1'b0, 1'b0, 2'b00);
    endtask

    initial begin
        n_vec  = 0;
        n_mis  = 0;
        n_slip = 0;
        rst_n  = 1'b0;
        bus.i_data_valid  = 1'b0;
        bus.i_headervalid = 1'b0;
        bus.i_header      = 2'b00;
        repeat (3) @(negedge clk);
        chk("rst_lock",   32'(bus.o_block_lock), 32'd0);
        chk("rst_slip",   32'(bus.o_slip),       32'd0);
        chk("rst_count",  32'(bus.o_slip_count), 32'd0);
        chk("rst_hiber",  32'(bus.o_hi_ber),     32'd0);
        rst_n = 1'b1;

        // Clean lock from reset.
        hdrs(63, 2'b01);
        idle();
        chk("lock_after_63", 32'(bus.o_block_lock), 32'd0);
        hdrs(1, 2'b01);
        idle();
        chk("lock_after_64", 32'(bus.o_block_lock), 32'd1);
        chk("count_clean",   32'(bus.o_slip_count), 32'd0);
        chk("no_slip_clean", 32'(n_slip),           32'd0);

        // 15 bad in one window holds lock; window end clears the count.
        hdrs(15, 2'b11);
        hdrs(49, 2'b01);
        idle();
        chk("lock_15_bad", 32'(bus.o_block_lock), 32'd1);
        hdrs(15, 2'b11);
        for (int i = 0; i < 10; i++) beat(1'b0, 1'b1, 2'b00);
        idle();
        chk("lock_invalid_beats", 32'(bus.o_block_lock), 32'd1);
        chk("no_slip_invalid",    32'(n_slip),           32'd0);
        hdrs(1, 2'b11);
        idle();
        chk("unlock_16th", 32'(bus.o_block_lock), 32'd0);
        chk("slip_16th",   32'(bus.o_slip),       32'd1);
        chk("count_1",     32'(bus.o_slip_count), 32'd1);
        idle();
        chk("slip_one_cycle", 32'(bus.o_slip), 32'd0);
        repeat (40) idle();

        // SEARCH: bad header slips; next 32 cycles of headers are discarded.
        hdrs(10, 2'b01);
        hdrs(1, 2'b11);
        for (int i = 0; i < 32; i++) begin
            beat(1'b1, 1'b1, 2'b11);
            if (i == 0) begin
                chk("search_slip",  32'(bus.o_slip),       32'd1);
                chk("search_count", 32'(bus.o_slip_count), 32'd2);
            end
            if (i == 1) chk("search_slip_end", 32'(bus.o_slip), 32'd0);
        end
        hdrs(63, 2'b01);
        idle();
        chk("relock_63",    32'(bus.o_block_lock), 32'd0);
        chk("wait_count",   32'(bus.o_slip_count), 32'd2);
        hdrs(1, 2'b01);
        idle();
        chk("relock_64",    32'(bus.o_block_lock), 32'd1);
        chk("slip_pulses",  32'(n_slip),           32'd2);

        // Reset during the slip pulse.
        hdrs(16, 2'b11);
        idle();
        chk("pre_rst_slip", 32'(bus.o_slip), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_pulse_slip",  32'(bus.o_slip),       32'd0);
        chk("rst_pulse_lock",  32'(bus.o_block_lock), 32'd0);
        chk("rst_pulse_count", 32'(bus.o_slip_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Reset in the middle of SLIP_WAIT, then a full clean relock.
        hdrs(1, 2'b11);
        idle();
        chk("wait_slip",  32'(bus.o_slip_count), 32'd1);
        repeat (5) idle();
        #1 rst_n = 1'b0;
        #1;
        chk("rst_wait_count", 32'(bus.o_slip_count), 32'd0);
        chk("rst_wait_slip",  32'(bus.o_slip),       32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        hdrs(63, 2'b01);
        idle();
        chk("post_rst_63", 32'(bus.o_block_lock), 32'd0);
        hdrs(1, 2'b01);
        idle();
        chk("post_rst_64", 32'(bus.o_block_lock), 32'd1);
        chk("post_rst_count", 32'(bus.o_slip_count), 32'd0);

`ifdef ETH_BLOCK_LOCK_HIBER_EN
        // 12 bad per 128-header window: no hi-BER, lock held.
        for (int w = 0; w < 2; w++)
            for (int i = 0; i < 128; i++) hdrs(1, ((i % 64) < 6) ? 2'b11 : 2'b01);
        idle();
        chk("hb_12_flag", 32'(bus.o_hi_ber),     32'd0);
        chk("hb_12_lock", 32'(bus.o_block_lock), 32'd1);
        // 8 + 8 bad across two lock windows: 16th bad sets hi-BER.
        for (int i = 0; i < 72; i++) hdrs(1, ((i % 64) < 8) ? 2'b11 : 2'b01);
        idle();
        chk("hb_16_flag", 32'(bus.o_hi_ber),     32'd1);
        chk("hb_16_lock", 32'(bus.o_block_lock), 32'd1);
        hdrs(56, 2'b01);
        idle();
        chk("hb_win_end_hold", 32'(bus.o_hi_ber), 32'd1);
        hdrs(128, 2'b01);
        idle();
        chk("hb_clean_clear", 32'(bus.o_hi_ber), 32'd0);
        // 1 bad per 4 headers: lock drops at the 16th bad.
        for (int i = 0; i < 61; i++) hdrs(1, ((i % 4) == 0) ? 2'b11 : 2'b01);
        idle();
        chk("hb_drop_lock", 32'(bus.o_block_lock), 32'd0);
        chk("hb_drop_slip", 32'(bus.o_slip),       32'd1);
        chk("hb_drop_flag", 32'(bus.o_hi_ber),     32'd0);
`else
        chk("hiber_tied", 32'(bus.o_hi_ber), 32'd0);
`endif

        repeat (2) idle();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/eth_block_lock.md
# eth_block_lock

Receive-side block-lock controller for the 64b/66b path. Sits between the gearbox and the descrambler. It watches the 2-bit sync header on every header-valid beat and declares block lock after a run of good headers. While unlocked, and on excessive bad headers while locked, it pulses a slip request to the gearbox to shift block alignment by one bit. The descrambler and everything downstream use `o_block_lock` to qualify their data.

## Interface
- `LOCK_COUNT`, 64: consecutive good headers required to declare lock.
- `INVALID_LIMIT`, 16: bad headers within one `LOCK_COUNT` window that drop lock.
- `SLIP_WAIT_CYCLES`, 32: i_clk cycles ignored after each slip; must be ≥1.
- `HIBER_WINDOW`, 1024: headers per hi-BER window; used only with `ETH_BLOCK_LOCK_HIBER_EN`.
- `i_clk`  in  1  clock.
- `i_rst_n`  in  1  reset, asynchronous, active-low; clock `i_clk`.
- `i_data_valid`  in  1  gearbox beat valid.
- `i_headervalid`  in  1  `i_header` carries a sync header this beat; ignored unless `i_data_valid`=1.
- `i_header`  in  2  sync header; good = 2'b01 or 2'b10, bad = 2'b00 or 2'b11.
- `o_slip`  out  1  single-cycle request to gearbox to slip one bit.
- `o_block_lock`  out  1  block alignment achieved.
- `o_slip_count`  out  16  slips since reset, saturating at 16'hFFFF.
- `o_hi_ber`  out  1  high bit-error-rate flag; tied 0 when the feature is compiled out.

## Operation
- A header event is a cycle with `i_data_valid`=1 and `i_headervalid`=1. All other cycles leave the counters unchanged.
- Counters:
  - `sh_cnt`: 0..`LOCK_COUNT`, width `$clog2(LOCK_COUNT+1)`.
  - `sh_invld_cnt`: 0..`INVALID_LIMIT`, width `$clog2(INVALID_LIMIT+1)`.
- States:
  - `SEARCH`: unlocked, testing headers.
  - `LOCKED`.
  - `SLIP_WAIT`: headers ignored, wait counter running.
- SEARCH:
  - Good header: `sh_cnt`++.
  - When `sh_cnt` reaches `LOCK_COUNT`: go to LOCKED, set `o_block_lock`=1, clear both counters.
  - Any bad header: pulse `o_slip`, increment `o_slip_count`, clear counters, go to SLIP_WAIT.
- LOCKED:
  - Every header event: `sh_cnt`++. A bad header also does `sh_invld_cnt`++.
  - If `sh_invld_cnt` reaches `INVALID_LIMIT`: clear `o_block_lock`, pulse `o_slip`, increment `o_slip_count`, clear counters, go to SLIP_WAIT. This takes priority over window end on the same event.
  - Else when `sh_cnt` reaches `LOCK_COUNT`: clear both counters and stay LOCKED.
- SLIP_WAIT:
  - The wait counter loads `SLIP_WAIT_CYCLES-1` on entry and counts every `i_clk` cycle, whether or not data is valid.
  - At 0, go to SEARCH. Header events during SLIP_WAIT are discarded.
- `o_slip_count` stays at 16'hFFFF once saturated; further slips still pulse `o_slip`.

## Timing
- Reset values: `o_slip`=0, `o_block_lock`=0, `o_slip_count`=0, `o_hi_ber`=0; state SEARCH; all counters 0.
- All outputs are registered.
- A header event at cycle t that triggers a transition updates `o_block_lock`, `o_slip` and `o_slip_count` at t+1.
- `o_slip` is high for exactly one cycle per slip.
- The next slip is at least `SLIP_WAIT_CYCLES`+1 cycles after the previous one.
- The first header evaluated after a slip is at t+1+`SLIP_WAIT_CYCLES` or later.
- Lock from reset with clean headers: `o_block_lock` rises the cycle after the `LOCK_COUNT`-th good header event.
- Asserting `i_rst_n` low at any time, including mid-SLIP_WAIT or during the `o_slip` pulse, returns all state and outputs to reset values asynchronously. `o_slip` never outlives reset assertion.

## Configuration
- `ETH_BLOCK_LOCK_HIBER_EN` defined:
  - The hi-BER monitor runs only while `o_block_lock`=1.
  - It counts header events in windows of `HIBER_WINDOW` and counts bad headers in each window, saturating at 16.
  - `o_hi_ber` is set the cycle after the 16th bad header in a window.
  - At window end, `o_hi_ber` takes (bad count ≥ 16) and the counts clear.
  - Loss of lock clears `o_hi_ber` and both monitor counts.
- `ETH_BLOCK_LOCK_HIBER_EN` undefined: no monitor logic; `o_hi_ber` is constant 0.

## Test plan
- Reset, then 64 header events of 2'b01 -> `o_block_lock` 0→1 one cycle after the 64th; `o_slip` never asserts; `o_slip_count`=0.
- In SEARCH, 10 good headers then one 2'b11 -> one-cycle `o_slip`, `o_slip_count`=1. Headers during the next 32 cycles are ignored; 64 further good headers then lock.
- Locked, 15 bad headers within one 64-header window -> stays locked; counters clear at window end. Next window with 16 bad -> `o_block_lock`=0 and `o_slip`=1 on the same cycle.
- `i_headervalid`=1 with `i_data_valid`=0 carrying 2'b00 -> no counter change, no slip.
- Reset asserted during SLIP_WAIT and during the `o_slip` pulse -> all outputs 0 immediately; a clean relock afterwards needs 64 good headers.
- With `ETH_BLOCK_LOCK_HIBER_EN` and `HIBER_WINDOW`=128, locked, 16 bad spread as 1 per 4 headers -> lock drops at the 16th bad (within window); with 12 bad per window -> `o_hi_ber` stays 0 and lock held.
